// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared scancode constants, controller FSM states and ROM address layout for the PS/2 key path.
// No logic, no latency, no backpressure.
package ps2_kbd_pkg;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_LANG   = 8'h0E;
  localparam int         ROM_AW    = 10;

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, LOOKUP, WAIT} state_t;

  typedef struct packed {
    logic       lang;
    logic       shift;
    logic [7:0] sc;
  } rom_addr_t;

  function automatic logic is_shift(input logic [7:0] b);
    return (b == SC_LSHIFT) || (b == SC_RSHIFT);
  endfunction

  function automatic logic is_mod(input logic [7:0] b);
    return is_shift(b) || (b == SC_CAPS) || (b == SC_LANG);
  endfunction
endpackage

// File: rtl/ps2_key_event_ctrl_fifo.sv
// Character FIFO: one-cycle write-to-valid latency, head shown combinationally (0 when empty).
// Backpressure: a write on full succeeds only if the head is popped in the same cycle.
module kbd_char_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_vld,
  input  logic [7:0] wr_dat,
  input  logic       rd_rdy,
  output logic [7:0] rd_dat,
  output logic       rd_vld,
  output logic       full
);
  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  DEPTH_C = FIFO_DEPTH[AW:0];

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign rd_vld  = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = rd_rdy && rd_vld;
  assign do_push = wr_vld && (!full || do_pop);
  assign rd_dat  = rd_vld ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 byte stream to ASCII: make accepted at T -> FIFO write at T+1+ROM_LAT; byte_ready low during lookup.
// Dropped characters on full FIFO set sticky overflow; AUTOREPEAT_SUPPRESS_EN suppresses typematic repeats.
module ps2_key_event_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ROM_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic [7:0]          char_out,
  output logic                char_valid,
  input  logic                char_ready,
  output logic                caps_led,
  output logic                lang,
  output logic                shift_eff,
  output logic                overflow
);
  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  state_t    state, state_nxt;
  rom_addr_t addr_q;
  logic      holding_shift, caps_held, lang_held;
  logic [1:0] lat_cnt;
  logic      accept, repeat_hit, make_go, lat_done, fifo_wr, fifo_full;

  assign accept    = byte_valid && byte_ready;
  assign shift_eff = holding_shift ^ caps_led;
  assign rom_addr  = addr_q;
  assign lat_done  = (lat_cnt == LAT_LAST);
  assign make_go   = (state == IDLE) && accept && (byte_in != SC_EXT) &&
                     (byte_in != SC_BREAK) && !is_mod(byte_in) && !repeat_hit;
  assign fifo_wr   = (state == WAIT) && lat_done && (rom_data != 8'h00);

`ifdef AUTOREPEAT_SUPPRESS_EN
  logic [7:0] rpt_sc;
  logic       rpt_armed;

  assign repeat_hit = rpt_armed && (byte_in == rpt_sc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_sc    <= 8'h00;
      rpt_armed <= 1'b0;
    end else if (make_go) begin
      rpt_sc    <= byte_in;
      rpt_armed <= 1'b1;
    end else if ((state == BRK) && accept && (byte_in == rpt_sc)) begin
      rpt_armed <= 1'b0;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          if (byte_in == SC_EXT)        state_nxt = EXT;
          else if (byte_in == SC_BREAK) state_nxt = BRK;
          else if (make_go)             state_nxt = LOOKUP;
        end
      end
      BRK, EXT_BRK: if (accept) state_nxt = IDLE;
      EXT: if (accept) state_nxt = (byte_in == SC_BREAK) ? EXT_BRK : IDLE;
      LOOKUP: begin
        byte_ready = 1'b0;
        state_nxt  = WAIT;
      end
      WAIT: begin
        byte_ready = 1'b0;
        if (lat_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Held flags make caps/lang toggle once per physical press despite typematic repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holding_shift <= 1'b0;
      caps_held     <= 1'b0;
      lang_held     <= 1'b0;
      caps_led      <= 1'b0;
      lang          <= 1'b0;
      addr_q        <= '0;
      lat_cnt       <= 2'd0;
      overflow      <= 1'b0;
    end else begin
      if ((state == IDLE) && accept) begin
        if (is_shift(byte_in)) holding_shift <= 1'b1;
        if (byte_in == SC_CAPS) begin
          caps_held <= 1'b1;
          if (!caps_held) caps_led <= ~caps_led;
        end
        if (byte_in == SC_LANG) begin
          lang_held <= 1'b1;
          if (!lang_held) lang <= ~lang;
        end
      end
      if ((state == BRK) && accept) begin
        if (is_shift(byte_in))  holding_shift <= 1'b0;
        if (byte_in == SC_CAPS) caps_held     <= 1'b0;
        if (byte_in == SC_LANG) lang_held     <= 1'b0;
      end
      if (make_go) addr_q <= '{lang: lang, shift: shift_eff, sc: byte_in};
      if (state == LOOKUP)    lat_cnt <= 2'd0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;
      if (fifo_wr && fifo_full && !char_ready) overflow <= 1'b1;
    end
  end

  kbd_char_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (fifo_wr),
    .wr_dat (rom_data),
    .rd_rdy (char_ready),
    .rd_dat (char_out),
    .rd_vld (char_valid),
    .full   (fifo_full)
  );
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed scenarios plus randomized key events against an event-level model.
module tb_ps2_key_event_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       caps_led, lang, shift_eff, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;  // 0 hold low, 1 random, 2 always high
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

`ifdef AUTOREPEAT_SUPPRESS_EN
  localparam bit SUPP = 1'b1;
`else
  localparam bit SUPP = 1'b0;
`endif

  ps2_key_event_ctrl dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .caps_led(caps_led), .lang(lang), .shift_eff(shift_eff), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    logic [7:0] sc;
    sc = a[7:0];
    if (sc == 8'h2C) return 8'h00;
    if (sc == 8'h1C) return a[9] ? 8'hC1 : (a[8] ? 8'h41 : 8'h61);
    return {a[9], a[8], sc[5:0]} | 8'h01;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Consumer: the pop happens at the posedge following this negedge.
  always @(negedge clk) begin
    case (ready_mode)
      1:       char_ready = ($urandom_range(0, 3) != 0);
      2:       char_ready = 1'b1;
      default: char_ready = 1'b0;
    endcase
    if (char_valid && char_ready) got_q.push_back(char_out);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (byte_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready byte=%h got byte_ready=%b want 1", b, byte_ready);
    end
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic flush();
    ready_mode = 2;
    repeat (12) @(negedge clk);
    ready_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #23;
    n_cmp++;
    if ({char_valid, char_out, rom_addr, caps_led, lang, shift_eff, overflow} !== 23'h0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b c=%h a=%h caps=%b lang=%b sh=%b ovf=%b want all 0",
               char_valid, char_out, rom_addr, caps_led, lang, shift_eff, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (byte_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_byte_ready got %b want 1", byte_ready);
    end
  endtask

  task automatic test_basic();
    got_q.delete();
    send(8'h1C);
    n_cmp++;
    if (rom_addr !== 10'h01C) begin n_err++; $display("FAIL basic_addr got %h want 01c", rom_addr); end
    n_cmp++;
    if (byte_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy got byte_ready=%b want 0", byte_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (char_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got char_valid=%b want 0", char_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (char_valid !== 1'b1 || char_out !== 8'h61) begin
      n_err++; $display("FAIL basic_char got v=%b c=%h want 1/61", char_valid, char_out);
    end
    send(8'hF0); send(8'h1C);
    repeat (4) @(negedge clk);
    flush();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'h61) begin
      n_err++; $display("FAIL basic_count got %0d chars want 1 (61)", got_q.size());
    end
  endtask

  task automatic test_shift();
    got_q.delete();
    send(8'h12);
    n_cmp++;
    if (shift_eff !== 1'b1) begin n_err++; $display("FAIL shift_on got %b want 1", shift_eff); end
    send(8'h1C);
    n_cmp++;
    if (rom_addr !== 10'h11C) begin n_err++; $display("FAIL shift_addr got %h want 11c", rom_addr); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (char_valid !== 1'b1 || char_out !== 8'h41) begin
      n_err++; $display("FAIL shift_char got v=%b c=%h want 1/41", char_valid, char_out);
    end
    send(8'hF0); send(8'h12);
    n_cmp++;
    if (shift_eff !== 1'b0) begin n_err++; $display("FAIL shift_off got %b want 0", shift_eff); end
    flush();
  endtask

  task automatic test_caps();
    got_q.delete();
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    n_cmp++;
    if (caps_led !== 1'b1) begin n_err++; $display("FAIL caps_once got %b want 1", caps_led); end
    send(8'h1C);
    n_cmp++;
    if (rom_addr !== 10'h11C) begin n_err++; $display("FAIL caps_addr got %h want 11c", rom_addr); end
    send(8'h12); send(8'h1C);
    n_cmp++;
    if (rom_addr !== 10'h01C) begin n_err++; $display("FAIL caps_shift_addr got %h want 01c", rom_addr); end
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    n_cmp++;
    if (caps_led !== 1'b0) begin n_err++; $display("FAIL caps_off got %b want 0", caps_led); end
    flush();
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== 8'h41 || got_q[1] !== 8'h61) begin
      n_err++; $display("FAIL caps_chars got %0d chars want 2 (41 61)", got_q.size());
    end
  endtask

  task automatic test_lang();
    got_q.delete();
    send(8'h0E); send(8'hF0); send(8'h0E);
    n_cmp++;
    if (lang !== 1'b1) begin n_err++; $display("FAIL lang_on got %b want 1", lang); end
    send(8'h1C);
    n_cmp++;
    if (rom_addr !== 10'h21C) begin n_err++; $display("FAIL lang_addr got %h want 21c", rom_addr); end
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (byte_ready !== 1'b1) begin n_err++; $display("FAIL ext_idle got byte_ready=%b want 1", byte_ready); end
    flush();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'hC1) begin
      n_err++; $display("FAIL lang_chars got %0d chars want 1 (c1)", got_q.size());
    end
    send(8'h0E); send(8'hF0); send(8'h0E);
    n_cmp++;
    if (lang !== 1'b0) begin n_err++; $display("FAIL lang_off got %b want 0", lang); end
  endtask

  task automatic test_autorepeat();
    int want;
    got_q.delete();
    ready_mode = 2;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    repeat (6) @(negedge clk);
    ready_mode = 0;
    want = SUPP ? 2 : 4;
    n_cmp++;
    if (got_q.size() != want) begin
      n_err++; $display("FAIL autorepeat_count got %0d want %0d", got_q.size(), want);
    end
    foreach (got_q[i]) begin
      n_cmp++;
      if (got_q[i] !== 8'h61) begin n_err++; $display("FAIL autorepeat_char got %h want 61", got_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    logic [9:0] a;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h1B};
    got_q.delete();
    foreach (codes[i]) send(codes[i]);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b1 || char_valid !== 1'b1) begin
      n_err++; $display("FAIL ovf_set got ovf=%b v=%b want 1/1", overflow, char_valid);
    end
    flush();
    n_cmp++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL ovf_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      a = {2'b00, codes[i]};
      n_cmp++;
      if (got_q[i] !== rom_fn(a)) begin
        n_err++; $display("FAIL ovf_order idx %0d got %h want %h", i, got_q[i], rom_fn(a));
      end
    end
    n_cmp++;
    if (overflow !== 1'b1 || char_valid !== 1'b0) begin
      n_err++; $display("FAIL ovf_sticky got ovf=%b v=%b want 1/0", overflow, char_valid);
    end
  endtask

  task automatic test_reset_wait();
    send(8'h15);
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'h1C);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({char_valid, char_out, rom_addr, caps_led, lang, shift_eff, overflow} !== 23'h0) begin
      n_err++;
      $display("FAIL reset_wait got v=%b c=%h a=%h caps=%b lang=%b sh=%b ovf=%b want all 0",
               char_valid, char_out, rom_addr, caps_led, lang, shift_eff, overflow);
    end
    n_cmp++;
    if (byte_ready !== 1'b1) begin n_err++; $display("FAIL reset_wait_ready got %b want 1", byte_ready); end
    #20;
    rst_n = 1'b1;
    got_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] mods [4];
    logic [7:0] c, last_sent;
    logic [9:0] a;
    bit m_shift, m_caps, m_lang, m_caps_dn, m_lang_dn, m_armed;
    logic [7:0] m_last;
    int k;
    pool = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h1C, 8'h1B, 8'h23};
    mods = '{8'h12, 8'h59, 8'h58, 8'h0E};
    {m_shift, m_caps, m_lang, m_caps_dn, m_lang_dn, m_armed} = '0;
    m_last = 8'h00; last_sent = 8'h1C;
    got_q.delete(); exp_q.delete();
    ready_mode = 1;
    for (int ev = 0; ev < 200; ev++) begin
      k = $urandom_range(0, 9);
      if (k <= 3 || k == 9) begin
        c = (k == 9) ? last_sent : pool[$urandom_range(0, 7)];
        last_sent = c;
        send(c);
        if (!(SUPP && m_armed && c == m_last)) begin
          a = {m_lang, m_shift ^ m_caps, c};
          if (rom_fn(a) != 8'h00) exp_q.push_back(rom_fn(a));
          m_last = c; m_armed = 1'b1;
        end
      end else if (k == 4) begin
        c = pool[$urandom_range(0, 7)];
        send(8'hF0); send(c);
        if (c == m_last) m_armed = 1'b0;
      end else if (k == 5) begin
        c = mods[$urandom_range(0, 3)];
        send(c);
        if (c == 8'h12 || c == 8'h59) m_shift = 1'b1;
        if (c == 8'h58) begin if (!m_caps_dn) m_caps = ~m_caps; m_caps_dn = 1'b1; end
        if (c == 8'h0E) begin if (!m_lang_dn) m_lang = ~m_lang; m_lang_dn = 1'b1; end
      end else if (k == 6) begin
        c = mods[$urandom_range(0, 3)];
        send(8'hF0); send(c);
        if (c == 8'h12 || c == 8'h59) m_shift = 1'b0;
        if (c == 8'h58) m_caps_dn = 1'b0;
        if (c == 8'h0E) m_lang_dn = 1'b0;
      end else if (k == 7) begin
        send(8'hE0); send(pool[$urandom_range(0, 7)]);
      end else begin
        send(8'hE0); send(8'hF0); send(pool[$urandom_range(0, 7)]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ready_mode = 2;
    repeat (20) @(negedge clk);
    ready_mode = 0;
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rand_char idx %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({caps_led, lang, shift_eff, overflow} !== {m_caps, m_lang, m_shift ^ m_caps, 1'b0}) begin
      n_err++;
      $display("FAIL rand_state got caps=%b lang=%b sh=%b ovf=%b want %b/%b/%b/0",
               caps_led, lang, shift_eff, overflow, m_caps, m_lang, m_shift ^ m_caps);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_lang();
    test_autorepeat();
    test_overflow();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
Sequences raw PS/2 keyboard bytes into ASCII characters. Parses make/break (F0) and extended (E0) prefixes, tracks shift, caps-lock and language state, and drives the shared synchronous scancode ROM. Buffers resulting characters in a small FIFO with a ready/valid output to the text/display path. Sits between the PS/2 byte receiver and the character consumer.

Parameters:
FIFO_DEPTH, 4, character FIFO entries; power of two, 2..16
ROM_LAT, 1, scancode ROM read latency in cycles; 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
byte_in  in  8  received PS/2 byte
byte_valid  in  1  byte_in valid this cycle
byte_ready  out  1  controller accepts byte this cycle
rom_addr  out  10  {lang, shift_eff, scancode} to scancode ROM
rom_data  in  8  ROM ASCII output, ROM_LAT cycles after rom_addr
char_out  out  8  FIFO head character
char_valid  out  1  FIFO non-empty
char_ready  in  1  consumer pops head when char_valid && char_ready
caps_led  out  1  caps-lock state
lang  out  1  language select, 0 = English, 1 = Thai
shift_eff  out  1  holding_shift XOR caps
overflow  out  1  sticky: a character was dropped on full FIFO

Behaviour:
- Reset (async, rst_n low): state IDLE; caps_led, lang, holding_shift, overflow = 0; FIFO empty (char_valid 0, char_out 0); rom_addr 0; byte_ready 1 after release.
- Byte accepted on byte_valid && byte_ready. byte_ready = 1 in IDLE/BRK/EXT/EXT_BRK, 0 in LOOKUP/WAIT.
- FSM:
  IDLE: E0 -> EXT; F0 -> BRK; modifier make -> apply, stay IDLE; other make -> LOOKUP (latch scancode).
  BRK: byte is break code; shift (12/59) break clears holding_shift; caps/lang break clears their held flags; -> IDLE. No character.
  EXT: F0 -> EXT_BRK; any other byte consumed, no char -> IDLE.
  EXT_BRK: consume byte -> IDLE.
  LOOKUP: drive rom_addr = {lang, shift_eff, scancode} (registered) -> WAIT.
  WAIT: count ROM_LAT cycles; on last, if rom_data != 00 write to FIFO, else discard (unmapped) -> IDLE.
- Modifiers: 12/59 make sets holding_shift. 58 make toggles caps_led only on first make (caps_held flag blocks auto-repeat toggles). 0E make toggles lang likewise (lang_held). Modifier makes never produce characters.
- Latency (ROM_LAT=1): make accepted cycle T; rom_addr valid T+1; rom_data sampled and FIFO written T+2; char_valid high T+3 if FIFO was empty.
- shift_eff sampled at LOOKUP; modifier changes cannot occur mid-lookup (byte_ready low).
- FIFO: write on full with no same-cycle pop -> char dropped, overflow set until reset. Write and pop in same cycle when full -> both succeed, count unchanged. Pop on empty ignored.
- Unexpected F0/E0 in BRK/EXT_BRK treated as the data byte; FSM always returns to IDLE (resynchronises).

Optional Feature:
AUTOREPEAT_SUPPRESS_EN defined: track last non-modifier make scancode; repeated make of the same code without intervening break emits no character (no ROM lookup). Break of that code, or a different make, re-arms. Undefined: every make, including typematic repeats, produces a lookup and character.

Decomposition:
- Package ps2_kbd_pkg: scancode constants (SC_EXT=E0, SC_BREAK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_LANG=0E), FSM state enum (IDLE, BRK, EXT, EXT_BRK, LOOKUP, WAIT), ROM address width 10.
- Sub-module kbd_char_fifo (parameter FIFO_DEPTH, 8-bit data, full/empty, simultaneous push/pop rule above).

Test Plan:
- Bytes 1C, F0 1C, lang=0, ROM[01C]=61 -> one char 61 ('a'), char_valid at T+3 after 1C accepted; break emits nothing.
- 12, 1C, F0 12 with ROM[11C]=41 -> rom_addr 11C, char 41; shift_eff returns 0 after F0 12.
- 58, 58, 58, F0 58 (held caps) -> caps_led toggles once to 1; then 1C -> rom_addr 11C; 12 then 1C -> rom_addr 01C.
- 0E, F0 0E then 1C -> lang=1, rom_addr 21C; E0 75, E0 F0 75 -> no char, FSM back to IDLE, byte_ready 1.
- char_ready=0, FIFO_DEPTH=4, five makes of mapped keys -> 4 chars stored, overflow=1; then pop all -> order preserved, overflow stays 1.
- rst_n low while in WAIT -> outputs zero immediately; AUTOREPEAT_SUPPRESS_EN: 1C,1C,1C,F0 1C,1C -> exactly two 'a' chars (one without the macro: four).
